mips_instr_encoder: RTL and testbench
=====================================

# mips_instr_encoder

Encoder side of the single-cycle/pipeline CPU instruction format: accepts symbolic operation requests (operation + register/immediate fields) over a valid/ready handshake and produces 32-bit MIPS instruction words. The words go through a small FIFO and are streamed with an auto-incrementing word address to the instruction-memory loader. It is the inverse of the control decoder's opcode/func mapping and supports exactly the same instruction set: add, addu, subu, and, or, slt, jr, addi, addiu, andi, ori, lui, sw, lw, beq, j, jal.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- ADDR_W, 10: word-address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request may be accepted; equals !full
- in_op  in  5  operation select (encoding below)
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  26  immediate; I-type uses [15:0], J-type uses [25:0]
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts word
- out_data  out  32  instruction word at FIFO head
- out_addr  out  ADDR_W  word address for out_data
- addr_clr  in  1  clear address counter
- err_op  out  1  one-cycle pulse: illegal in_op was accepted and dropped
- count  out  ADDR_W+1  words delivered since reset; saturates at all-ones

## Operation
- in_op: 0 ADD, 1 ADDU, 2 SUBU, 3 AND, 4 OR, 5 SLT, 6 JR, 7 ADDI, 8 ADDIU, 9 ANDI, 10 ORI, 11 LUI, 12 SW, 13 LW, 14 BEQ, 15 J, 16 JAL. Values 17–31 are illegal.
- R-type, ops 0–6: opcode 000000, {rs,rt,rd}, shamt 0. func values: 100000, 100001, 100011, 100100, 100101, 101010, 001000. JR forces rt=rd=0.
- I-type: opcodes ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101, LUI 001111, SW 101011, LW 100011, BEQ 000100. Word = {opcode, rs, rt, in_imm[15:0]}. LUI forces rs=0. in_rd is ignored.
- J-type: J 000010, JAL 000011. Word = {opcode, in_imm[25:0]}.
- Accept condition: in_valid && in_ready.
  - Legal op: encode combinationally and push into the FIFO.
  - Illegal op: the request is consumed but nothing is pushed, and err_op is high in the following cycle.
- Deliver condition: out_valid && out_ready.
  - FIFO pops.
  - out_addr increments, wrapping from 2^ADDR_W−1 to 0.
  - count increments.
- addr_clr: next out_addr = 0. This takes priority over a simultaneous delivery increment, but the delivery itself still completes and count still increments.
- The FIFO has no bypass when full. in_ready depends only on the registered fill level, never on out_ready.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_addr 0, err_op 0, count 0, FIFO empty.
- rst mid-stream drops all queued words and pending err_op.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N; this is 1 cycle when the FIFO was empty.
- out_data must be 0 whenever out_valid=0.
- out_data and out_addr hold stable while out_valid && !out_ready.
- Simultaneous push and pop when not full: occupancy is unchanged and order is preserved.
- Full (DEPTH entries): in_ready=0. A pop in that cycle frees a slot, which becomes visible as in_ready=1 only after the edge.
- Throughput: one word per cycle sustained when out_ready is held at 1.

## Structure
- Package mips_isa_pkg holds:
  - the in_op enum;
  - OPCODE_* and FUNC_* 6-bit constants, shared with the control decoder;
  - a pure function encode_instr(op, rs, rt, rd, imm) returning {legal, word[31:0]}.
- Sub-module instr_fifo: synchronous FIFO with DEPTH/WIDTH parameters, push/pop/full/empty, and pointer-wrap plus extra-bit full detection.
- The top level holds the handshake logic, address counter, saturating count, and err_op register.

## Test plan
- Reset, then ADD rs=1 rt=2 rd=3 with out_ready=1 → next cycle out_valid=1, out_data=0x00221820, out_addr=0; count becomes 1.
- Back-to-back ADDI 1,2,0x0005; LW rs=29 rt=8 imm=4; LUI rt=1 imm=0x1234 with rs=7; BEQ 1,2,0xFFFF → outputs in order:
  - 0x20220005 at address 0;
  - 0x8FA80004 at address 1;
  - 0x3C011234 at address 2;
  - 0x1022FFFF at address 3.
- J imm=0x100, JAL imm=0x100, JR rs=31 rt=5 rd=6 → 0x08000100, 0x0C000100, 0x03E00008.
- out_ready=0 with 5 requests offered (DEPTH=4) → 4 accepted, then in_ready=0 and out_data stable. Release out_ready → the 4 words drain in order, the 5th is accepted after the first pop edge, and no loss or duplication occurs.
- in_op=20 → handshake completes, err_op pulses exactly 1 cycle, out_valid stays 0, count unchanged.
- With ADDR_W=2: deliver 5 words → addresses 0,1,2,3,0. Assert addr_clr together with the 3rd delivery → next address 0 and count still increments. Assert rst with 2 words queued → out_valid=0 and out_addr=0 on the next cycle.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared between the instruction encoder and the control
// decoder, plus a pure encoding function for symbolic operation requests.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUBU  = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_SLT   = 5'd5,
    OP_JR    = 5'd6,
    OP_ADDI  = 5'd7,
    OP_ADDIU = 5'd8,
    OP_ANDI  = 5'd9,
    OP_ORI   = 5'd10,
    OP_LUI   = 5'd11,
    OP_SW    = 5'd12,
    OP_LW    = 5'd13,
    OP_BEQ   = 5'd14,
    OP_J     = 5'd15,
    OP_JAL   = 5'd16
  } instr_op_e;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0] OPCODE_ADDI  = 6'b001000;
  localparam logic [5:0] OPCODE_ADDIU = 6'b001001;
  localparam logic [5:0] OPCODE_ANDI  = 6'b001100;
  localparam logic [5:0] OPCODE_ORI   = 6'b001101;
  localparam logic [5:0] OPCODE_LUI   = 6'b001111;
  localparam logic [5:0] OPCODE_SW    = 6'b101011;
  localparam logic [5:0] OPCODE_LW    = 6'b100011;
  localparam logic [5:0] OPCODE_BEQ   = 6'b000100;
  localparam logic [5:0] OPCODE_J     = 6'b000010;
  localparam logic [5:0] OPCODE_JAL   = 6'b000011;

  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;
  localparam logic [5:0] FUNC_JR   = 6'b001000;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  // Map a symbolic request onto its 32-bit instruction word; illegal ops
  // come back with legal=0 and a zero word.
  function automatic enc_t encode_instr(input logic [4:0]  op,
                                        input logic [4:0]  rs,
                                        input logic [4:0]  rt,
                                        input logic [4:0]  rd,
                                        input logic [25:0] imm);
    enc_t r;
    r.legal = 1'b1;
    r.word  = '0;
    case (op)
      OP_ADD:   r.word = {OPCODE_RTYPE, rs, rt, rd, 5'd0, FUNC_ADD};
      OP_ADDU:  r.word = {OPCODE_RTYPE, rs, rt, rd, 5'd0, FUNC_ADDU};
      OP_SUBU:  r.word = {OPCODE_RTYPE, rs, rt, rd, 5'd0, FUNC_SUBU};
      OP_AND:   r.word = {OPCODE_RTYPE, rs, rt, rd, 5'd0, FUNC_AND};
      OP_OR:    r.word = {OPCODE_RTYPE, rs, rt, rd, 5'd0, FUNC_OR};
      OP_SLT:   r.word = {OPCODE_RTYPE, rs, rt, rd, 5'd0, FUNC_SLT};
      OP_JR:    r.word = {OPCODE_RTYPE, rs, 5'd0, 5'd0, 5'd0, FUNC_JR};
      OP_ADDI:  r.word = {OPCODE_ADDI,  rs, rt, imm[15:0]};
      OP_ADDIU: r.word = {OPCODE_ADDIU, rs, rt, imm[15:0]};
      OP_ANDI:  r.word = {OPCODE_ANDI,  rs, rt, imm[15:0]};
      OP_ORI:   r.word = {OPCODE_ORI,   rs, rt, imm[15:0]};
      OP_LUI:   r.word = {OPCODE_LUI,   5'd0, rt, imm[15:0]};
      OP_SW:    r.word = {OPCODE_SW,    rs, rt, imm[15:0]};
      OP_LW:    r.word = {OPCODE_LW,    rs, rt, imm[15:0]};
      OP_BEQ:   r.word = {OPCODE_BEQ,   rs, rt, imm[15:0]};
      OP_J:     r.word = {OPCODE_J,     imm};
      OP_JAL:   r.word = {OPCODE_JAL,   imm};
      default:  r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Request and instruction-word stream signals of the encoder.
interface mips_instr_encoder_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [25:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
    input  in_ready, out_valid, out_data, out_addr
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
    output in_ready, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage write; the data array itself is never reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
  end

  // Read/write pointer advance; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_dout  = r_mem[r_rd_ptr[PTR_W-1:0]];
endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS requests into instruction words and streams them,
// with an auto-incrementing word address, to the instruction-memory loader.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  mips_instr_encoder_if.slave bus,
  input  logic                addr_clr,
  output logic                err_op,
  output logic [ADDR_W:0]     count
);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  enc_t              w_enc;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [31:0]       w_head;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_err_op;

  // Delivered-word counter sticks at all-ones instead of wrapping.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v == '1) ? v : v + {{ADDR_W{1'b0}}, 1'b1};
  endfunction

  assign w_enc    = encode_instr(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm);
  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_push   = w_accept && w_enc.legal;
  assign w_pop    = bus.out_valid && bus.out_ready;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_enc.word),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // in_ready follows only the registered fill level, so a pop never
  // frees a slot within the same cycle.
  assign bus.in_ready  = !w_full;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = bus.out_valid ? w_head : 32'd0;
  assign bus.out_addr  = r_addr;
  assign count         = r_count;
  assign err_op        = r_err_op;

  // Word address: clear wins over the delivery increment.
  always_ff @(posedge clk) begin
    if (rst)           r_addr <= '0;
    else if (addr_clr) r_addr <= '0;
    else if (w_pop)    r_addr <= r_addr + ADDR_ONE;
  end

  // Saturating count of delivered words.
  always_ff @(posedge clk) begin
    if (rst)        r_count <= '0;
    else if (w_pop) r_count <= sat_inc(r_count);
  end

  // One-cycle flag for an accepted request whose op was dropped as illegal.
  always_ff @(posedge clk) begin
    if (rst) r_err_op <= 1'b0;
    else     r_err_op <= w_accept && !w_enc.legal;
  end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: a negedge monitor predicts every
// output from a table-driven ISA model while the driver issues requests.
module tb_mips_instr_encoder;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;
  localparam int CNT_MAX = (1 << (ADDR_W + 1)) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            addr_clr = 1'b0;
  logic            err_op;
  logic [ADDR_W:0] count;

  mips_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  mips_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .addr_clr (addr_clr),
    .err_op   (err_op),
    .count    (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ISA model from opcode/func tables; returns {legal, word}.
  function automatic logic [32:0] ref_enc(input int op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [25:0] imm);
    logic [31:0] opc [17] = '{0, 0, 0, 0, 0, 0, 0, 8, 9, 12, 13, 15, 43, 35, 4, 2, 3};
    logic [31:0] fn  [7]  = '{32, 33, 35, 36, 37, 42, 8};
    logic [31:0] vrs, vrt, vrd, w;
    vrs = {27'd0, rs};
    vrt = {27'd0, rt};
    vrd = {27'd0, rd};
    if (op < 0 || op > 16) return 33'd0;
    if (op <= 6) begin
      if (op == 6) begin
        vrt = 0;
        vrd = 0;
      end
      w = (vrs << 21) | (vrt << 16) | (vrd << 11) | fn[op];
    end else if (op >= 15) begin
      w = (opc[op] << 26) | {6'd0, imm};
    end else begin
      if (op == 11) vrs = 0;
      w = (opc[op] << 26) | (vrs << 21) | (vrt << 16) | {16'd0, imm[15:0]};
    end
    return {1'b1, w};
  endfunction

  // Scoreboard state
  logic [31:0] sb [$];
  logic [31:0] log_d [$];
  int          log_a [$];
  int          m_addr = 0;
  int          m_cnt  = 0;
  bit          m_err  = 1'b0;
  bit          mon_en = 1'b0;
  logic [32:0] mon_e;

  // Monitor: compare every observable output, then advance the model for
  // the edge that follows.
  always @(negedge clk) begin
    if (mon_en) begin
      check(bus.out_valid == (sb.size() != 0), "out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) check(bus.out_data == sb[0], "out_data", bus.out_data, sb[0]);
      else                check(bus.out_data == 32'd0, "out_data_idle", bus.out_data, 32'd0);
      check(32'(bus.out_addr) == 32'(m_addr), "out_addr", 32'(bus.out_addr), 32'(m_addr));
      check(32'(count) == 32'(m_cnt), "count", 32'(count), 32'(m_cnt));
      check(bus.in_ready == (sb.size() < DEPTH), "in_ready", 32'(bus.in_ready), 32'(sb.size() < DEPTH));
      check(err_op == m_err, "err_op", 32'(err_op), 32'(m_err));
      if (rst) begin
        sb.delete();
        m_addr = 0;
        m_cnt  = 0;
        m_err  = 1'b0;
      end else begin
        m_err = 1'b0;
        if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
          log_d.push_back(bus.out_data);
          log_a.push_back(32'(bus.out_addr));
          void'(sb.pop_front());
          if (m_cnt < CNT_MAX) m_cnt++;
          m_addr = (m_addr + 1) % (1 << ADDR_W);
        end
        if (addr_clr) m_addr = 0;
        if (bus.in_valid && bus.in_ready) begin
          mon_e = ref_enc(int'(bus.in_op), bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm);
          if (mon_e[32]) sb.push_back(mon_e[31:0]);
          else           m_err = 1'b1;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one request and hold it until accepted (bounded wait).
  task automatic send(input int op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [25:0] imm);
    int t;
    bus.in_valid = 1'b1;
    bus.in_op    = 5'(op);
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_imm   = imm;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check(1'b0, "accept_timeout", 32'(t), 32'd200);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 200) begin
      wait_cyc(1);
      t++;
    end
    check(t < 200, "drain_timeout", 32'(t), 32'd200);
  endtask

  bit rnd_on = 1'b0;
  int bp_op [5];
  logic [4:0] bp_rs [5], bp_rt [5], bp_rd [5];
  logic [25:0] bp_imm [5];
  logic [31:0] bp_exp [5];
  logic [32:0] tmp_e;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rs     = '0;
    bus.in_rt     = '0;
    bus.in_rd     = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    wait_cyc(1);
    rst = 1'b0;

    // Single ADD
    bus.out_ready = 1'b1;
    send(0, 5'd1, 5'd2, 5'd3, 26'd0);
    wait_cyc(1);
    check(log_d.size() == 1, "add_delivered", 32'(log_d.size()), 32'd1);
    if (log_d.size() >= 1) begin
      check(log_d[0] == 32'h00221820, "add_word", log_d[0], 32'h00221820);
      check(log_a[0] == 0, "add_addr", 32'(log_a[0]), 32'd0);
    end
    check(32'(count) == 32'd1, "add_count", 32'(count), 32'd1);

    // I-type and J-type sequences, addresses wrapping 3 -> 0
    addr_clr = 1'b1;
    wait_cyc(1);
    addr_clr = 1'b0;
    log_d.delete();
    log_a.delete();
    send(7,  5'd1,  5'd2, 5'd0, 26'h0005);
    send(13, 5'd29, 5'd8, 5'd0, 26'h0004);
    send(11, 5'd7,  5'd1, 5'd0, 26'h1234);
    send(14, 5'd1,  5'd2, 5'd0, 26'hFFFF);
    send(15, 5'd0,  5'd0, 5'd0, 26'h100);
    send(16, 5'd0,  5'd0, 5'd0, 26'h100);
    send(6,  5'd31, 5'd5, 5'd6, 26'd0);
    wait_cyc(1);
    check(log_d.size() == 7, "seq_delivered", 32'(log_d.size()), 32'd7);
    if (log_d.size() == 7) begin
      logic [31:0] exp_w [7] = '{32'h20220005, 32'h8FA80004, 32'h3C011234, 32'h1022FFFF,
                                 32'h08000100, 32'h0C000100, 32'h03E00008};
      int exp_a [7] = '{0, 1, 2, 3, 0, 1, 2};
      for (int i = 0; i < 7; i++) begin
        check(log_d[i] == exp_w[i], "seq_word", log_d[i], exp_w[i]);
        check(log_a[i] == exp_a[i], "seq_addr", 32'(log_a[i]), 32'(exp_a[i]));
      end
    end
    check(32'(count) == 32'(CNT_MAX), "count_saturate", 32'(count), 32'(CNT_MAX));

    // Reset with two words queued
    bus.out_ready = 1'b0;
    send(1, 5'd3, 5'd4, 5'd5, 26'd0);
    send(9, 5'd3, 5'd4, 5'd5, 26'h00FF);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check(bus.out_valid == 1'b0, "rst_out_valid", 32'(bus.out_valid), 32'd0);
    check(32'(bus.out_addr) == 32'd0, "rst_out_addr", 32'(bus.out_addr), 32'd0);
    check(32'(count) == 32'd0, "rst_count", 32'(count), 32'd0);

    // Illegal op
    send(20, 5'd1, 5'd1, 5'd1, 26'd0);
    @(negedge clk);
    check(err_op == 1'b1, "err_pulse_hi", 32'(err_op), 32'd1);
    @(negedge clk);
    check(err_op == 1'b0, "err_pulse_lo", 32'(err_op), 32'd0);
    check(bus.out_valid == 1'b0, "err_no_word", 32'(bus.out_valid), 32'd0);
    check(32'(count) == 32'd0, "err_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: fill, stall, then drain with a fifth request waiting
    log_d.delete();
    log_a.delete();
    for (int i = 0; i < 5; i++) begin
      bp_op[i]  = int'($urandom_range(0, 16));
      bp_rs[i]  = 5'($urandom);
      bp_rt[i]  = 5'($urandom);
      bp_rd[i]  = 5'($urandom);
      bp_imm[i] = 26'($urandom);
      tmp_e     = ref_enc(bp_op[i], bp_rs[i], bp_rt[i], bp_rd[i], bp_imm[i]);
      bp_exp[i] = tmp_e[31:0];
    end
    for (int i = 0; i < 4; i++) send(bp_op[i], bp_rs[i], bp_rt[i], bp_rd[i], bp_imm[i]);
    check(bus.in_ready == 1'b0, "full_in_ready", 32'(bus.in_ready), 32'd0);
    wait_cyc(2);
    check(bus.out_data == bp_exp[0], "stall_head", bus.out_data, bp_exp[0]);
    fork
      send(bp_op[4], bp_rs[4], bp_rt[4], bp_rd[4], bp_imm[4]);
      begin
        wait_cyc(2);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check(log_d.size() == 5, "bp_delivered", 32'(log_d.size()), 32'd5);
    if (log_d.size() == 5)
      for (int i = 0; i < 5; i++) check(log_d[i] == bp_exp[i], "bp_order", log_d[i], bp_exp[i]);

    // addr_clr together with the third delivery
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    log_d.delete();
    log_a.delete();
    for (int i = 0; i < 4; i++) send(4, 5'(i), 5'(i + 1), 5'(i + 2), 26'd0);
    bus.out_ready = 1'b1;
    wait_cyc(1);
    wait_cyc(1);
    addr_clr = 1'b1;
    wait_cyc(1);
    addr_clr = 1'b0;
    wait_cyc(1);
    check(log_a.size() == 4, "clr_delivered", 32'(log_a.size()), 32'd4);
    if (log_a.size() == 4) begin
      int exp_a [4] = '{0, 1, 2, 0};
      for (int i = 0; i < 4; i++) check(log_a[i] == exp_a[i], "clr_addr", 32'(log_a[i]), 32'(exp_a[i]));
    end
    check(32'(count) == 32'd4, "clr_count", 32'(count), 32'd4);

    // Randomised traffic with random backpressure and address clears
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          addr_clr      = ($urandom_range(0, 15) == 0);
          wait_cyc(1);
        end
      end
      begin
        for (int i = 0; i < 200; i++) begin
          int op;
          op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
          send(op, 5'($urandom), 5'($urandom), 5'($urandom), 26'($urandom));
          if ($urandom_range(0, 3) == 0) wait_cyc(1);
        end
        rnd_on = 1'b0;
      end
    join
    addr_clr = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    wait_cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
